// File: rtl/pipe_ctrl_pkg.sv
// Shared stall encodings and FSM state types
// for the pipeline stall/sequencing controller.
package pipe_ctrl_pkg;

  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;

  typedef enum logic {
    MC_IDLE,
    MC_BUSY
  } mc_state_t;

  typedef enum logic {
    MW_IDLE,
    MW_WAIT
  } mw_state_t;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Request/stall bundle between the pipeline
// stages and the stall controller.
interface pipe_ctrl_if #(
  parameter int CNT_W = 6
);
  import pipe_ctrl_pkg::*;

  logic             flush;
  logic             stallreq_id;
  logic             ex_mc_start;
  logic [CNT_W-1:0] ex_mc_cycles;
  logic             mem_req;
  logic             mem_ack;
  logic [5:0]       stall;
  logic             ex_mc_busy;
  logic             ex_mc_last;
  logic             mem_timeout;

  modport master (
    output flush, stallreq_id, ex_mc_start,
    output ex_mc_cycles, mem_req, mem_ack,
    input  stall, ex_mc_busy, ex_mc_last,
    input  mem_timeout
  );

  modport slave (
    input  flush, stallreq_id, ex_mc_start,
    input  ex_mc_cycles, mem_req, mem_ack,
    output stall, ex_mc_busy, ex_mc_last,
    output mem_timeout
  );

endinterface

// File: rtl/pipe_ctrl_mc_counter.sv
// Loadable down-counter with enable and zero
// flag, used for EX multi-cycle sequencing.
module mc_counter
  import pipe_ctrl_pkg::*;
#(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/pipe_ctrl.sv
// Merges ID/EX/MEM stall sources into the
// stage freeze vector; owns EX and MEM FSMs.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W   = 6,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic        clk,
  input  logic        rst,
  pipe_ctrl_if.slave  bus
);

  localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT);

  mw_state_t       mw_q, mw_d;
  logic [TO_W-1:0] tcnt_q, tcnt_d;
  logic            mem_stall, mem_to;

  mc_state_t       mc_q, mc_d;
  logic            ex_stall, ex_last;
  logic            mc_load, mc_en, cnt_zero;
  logic            live;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mw_q   <= MW_IDLE;
      tcnt_q <= '0;
      mc_q   <= MC_IDLE;
    end else begin
      mw_q   <= mw_d;
      tcnt_q <= tcnt_d;
      mc_q   <= mc_d;
    end
  end

  always_comb begin
    mw_d      = mw_q;
    tcnt_d    = tcnt_q;
    mem_stall = 1'b0;
    mem_to    = 1'b0;
    unique case (mw_q)
      MW_IDLE: begin
        if (bus.mem_req && !bus.mem_ack) begin
          mem_stall = 1'b1;
          tcnt_d    = TO_W'(1);
          mw_d      = MW_WAIT;
        end
      end
      MW_WAIT: begin
        if (!bus.mem_req || bus.mem_ack) begin
          mw_d   = MW_IDLE;
          tcnt_d = '0;
        end else if (tcnt_q >= TO_LIM) begin
          mem_to = 1'b1;
          mw_d   = MW_IDLE;
          tcnt_d = '0;
        end else begin
          mem_stall = 1'b1;
          tcnt_d    = tcnt_q + TO_W'(1);
        end
      end
      default: mw_d = MW_IDLE;
    endcase
    if (bus.flush) begin
      mw_d   = MW_IDLE;
      tcnt_d = '0;
    end
  end

  // EX count freezes while MEM holds the pipe
  always_comb begin
    mc_d     = mc_q;
    ex_stall = 1'b0;
    ex_last  = 1'b0;
    mc_load  = 1'b0;
    mc_en    = 1'b0;
    unique case (mc_q)
      MC_IDLE: begin
        if (bus.ex_mc_start &&
            bus.ex_mc_cycles != '0 &&
            !mem_stall) begin
          ex_stall = 1'b1;
          mc_load  = 1'b1;
          mc_d     = MC_BUSY;
        end
      end
      MC_BUSY: begin
        if (!cnt_zero) begin
          ex_stall = 1'b1;
          mc_en    = !mem_stall;
        end else begin
          ex_last = 1'b1;
          if (!mem_stall) mc_d = MC_IDLE;
        end
      end
      default: mc_d = MC_IDLE;
    endcase
    if (bus.flush) mc_d = MC_IDLE;
  end

  mc_counter #(.W(CNT_W)) u_mc_counter (
    .clk      (clk),
    .rst      (rst),
    .clr      (bus.flush),
    .load     (mc_load),
    .load_val (bus.ex_mc_cycles - CNT_W'(1)),
    .en       (mc_en),
    .zero     (cnt_zero)
  );

  assign live = rst && !bus.flush;

  always_comb begin
    bus.stall = STALL_NONE;
    if (live) begin
      priority case (1'b1)
        mem_stall:       bus.stall = STALL_MEM;
        ex_stall:        bus.stall = STALL_EX;
        bus.stallreq_id: bus.stall = STALL_ID;
        default:         bus.stall = STALL_NONE;
      endcase
    end
  end

  assign bus.ex_mc_busy  = (mc_q == MC_BUSY);
  assign bus.ex_mc_last  = live && ex_last;
  assign bus.mem_timeout = live && mem_to;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl with a cycle
// model checked on every falling edge.
module tb_pipe_ctrl;

  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_ctrl_if #(.CNT_W(6)) bus ();

  pipe_ctrl #(
    .CNT_W   (6),
    .TIMEOUT (TO),
    .TO_W    (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  function automatic void chk(input string nm,
                              input logic [7:0] act,
                              input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t",
               nm, act, exp, $time);
    end
  endfunction

  // Model: k = cycles the current access has
  // stalled; ex tracks N and stall cycles served.
  int m_k = 0, n_k = 0;
  bit m_on = 0, n_on = 0;
  int m_n = 0, n_n = 0;
  int m_sv = 0, n_sv = 0;

  always @(negedge clk) begin : model_cmp
    bit ms, mt, es, el;
    logic [5:0] e_stall;
    ms = 0; mt = 0; es = 0; el = 0;
    e_stall = 6'b000000;
    n_k = 0; n_on = m_on; n_n = m_n; n_sv = m_sv;
    if (!rst) begin
      n_on = 0; n_n = 0; n_sv = 0;
    end else begin
      if (bus.mem_req && !bus.mem_ack) begin
        if (m_k < TO) begin
          ms = 1;
          n_k = m_k + 1;
        end else begin
          mt = 1;
        end
      end
      if (!m_on) begin
        if (bus.ex_mc_start &&
            bus.ex_mc_cycles != 0 && !ms) begin
          es = 1; n_on = 1;
          n_n = int'(bus.ex_mc_cycles);
          n_sv = 1;
        end
      end else if (m_sv < m_n) begin
        es = 1;
        if (!ms) n_sv = m_sv + 1;
      end else begin
        el = 1;
        if (!ms) n_on = 0;
      end
      if (ms) e_stall = 6'b011111;
      else if (es) e_stall = 6'b001111;
      else if (bus.stallreq_id) e_stall = 6'b000111;
      if (bus.flush) begin
        e_stall = 6'b000000;
        el = 0; mt = 0;
        n_on = 0; n_k = 0;
      end
    end
    chk("m_stall", {2'b00, bus.stall}, {2'b00, e_stall});
    chk("m_busy", {7'd0, bus.ex_mc_busy}, {7'd0, m_on});
    chk("m_last", {7'd0, bus.ex_mc_last}, {7'd0, el});
    chk("m_tout", {7'd0, bus.mem_timeout}, {7'd0, mt});
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_k <= 0; m_on <= 0; m_n <= 0; m_sv <= 0;
    end else begin
      m_k <= n_k; m_on <= n_on;
      m_n <= n_n; m_sv <= n_sv;
    end
  end

  task automatic set_in(input bit id, input bit st,
                        input int n, input bit rq,
                        input bit ak, input bit fl);
    bus.stallreq_id  = id;
    bus.ex_mc_start  = st;
    bus.ex_mc_cycles = 6'(n);
    bus.mem_req      = rq;
    bus.mem_ack      = ak;
    bus.flush        = fl;
  endtask

  task automatic go(input bit id, input bit st,
                    input int n, input bit rq,
                    input bit ak, input bit fl);
    set_in(id, st, n, rq, ak, fl);
    #3;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string nm,
                     input logic [5:0] exp);
    chk(nm, {2'b00, bus.stall}, {2'b00, exp});
  endtask

  logic [5:0] ex3 [4];
  logic [5:0] exb [4];

  initial begin
    ex3 = '{6'h0f, 6'h0f, 6'h0f, 6'h00};
    exb = '{6'h00, 6'h01, 6'h01, 6'h01};
    rst = 1'b0;
    set_in(1, 0, 0, 1, 0, 0);
    #2;
    lit("rst_stall", 6'h00);
    chk("rst_busy", {7'd0, bus.ex_mc_busy}, 8'd0);
    tick();
    set_in(0, 0, 0, 0, 0, 0);
    tick();
    rst = 1'b1;

    go(1, 0, 0, 0, 0, 0); lit("id_hz", 6'h07); tick();
    go(0, 0, 0, 0, 0, 0); lit("id_off", 6'h00); tick();

    for (int i = 0; i < 4; i++) begin
      go(0, 1, 3, 0, 0, 0);
      lit("ex3", ex3[i]);
      chk("ex3_busy", {7'd0, bus.ex_mc_busy},
          {2'b00, exb[i]});
      chk("ex3_last", {7'd0, bus.ex_mc_last},
          (i == 3) ? 8'd1 : 8'd0);
      tick();
    end
    go(0, 0, 0, 0, 0, 0);
    chk("ex3_done", {7'd0, bus.ex_mc_busy}, 8'd0);
    tick();

    for (int i = 0; i < 4; i++) begin
      go(0, 0, 0, 1, 0, 0); lit("mw", 6'h1f); tick();
    end
    go(0, 0, 0, 1, 1, 0); lit("mw_ack", 6'h00); tick();
    go(0, 0, 0, 0, 0, 0); tick();

    for (int i = 0; i < 2; i++) begin
      go(0, 1, 2, 1, 0, 0); lit("ov_mem", 6'h1f);
      chk("ov_busy", {7'd0, bus.ex_mc_busy}, 8'd0);
      tick();
    end
    go(0, 1, 2, 1, 1, 0); lit("ov_ex0", 6'h0f); tick();
    go(0, 1, 2, 0, 0, 0); lit("ov_ex1", 6'h0f); tick();
    go(0, 1, 2, 0, 0, 0); lit("ov_last", 6'h00);
    chk("ov_lastf", {7'd0, bus.ex_mc_last}, 8'd1);
    tick();
    go(0, 0, 0, 0, 0, 0); tick();

    for (int i = 0; i < 4; i++) begin
      go(0, 0, 0, 1, 0, 0); lit("to_wait", 6'h1f); tick();
    end
    go(0, 0, 0, 1, 0, 0); lit("to_abort", 6'h00);
    chk("to_pulse", {7'd0, bus.mem_timeout}, 8'd1);
    tick();
    go(0, 0, 0, 0, 0, 0);
    chk("to_once", {7'd0, bus.mem_timeout}, 8'd0);
    tick();

    for (int i = 0; i < 4; i++) begin
      go(0, 0, 0, 1, 0, 0); tick();
    end
    go(0, 0, 0, 1, 1, 0); lit("ackto", 6'h00);
    chk("ackto_np", {7'd0, bus.mem_timeout}, 8'd0);
    tick();
    go(0, 0, 0, 0, 0, 0); tick();

    go(0, 1, 3, 0, 0, 0); lit("fz0", 6'h0f); tick();
    go(0, 1, 3, 1, 0, 0); lit("fz1", 6'h1f); tick();
    go(0, 1, 3, 1, 0, 0); lit("fz2", 6'h1f); tick();
    go(0, 1, 3, 1, 1, 0); lit("fz3", 6'h0f); tick();
    go(0, 1, 3, 0, 0, 0); lit("fz4", 6'h0f); tick();
    go(0, 1, 3, 1, 0, 0); lit("fz_hold", 6'h1f);
    chk("fz_hl", {7'd0, bus.ex_mc_last}, 8'd1);
    tick();
    go(0, 1, 3, 1, 1, 0); lit("fz_rel", 6'h00); tick();
    go(0, 0, 0, 0, 0, 0);
    chk("fz_idle", {7'd0, bus.ex_mc_busy}, 8'd0);
    tick();

    go(0, 1, 0, 0, 0, 0); lit("n0", 6'h00); tick();
    go(0, 1, 1, 0, 0, 0); lit("n1_s", 6'h0f); tick();
    go(0, 1, 1, 0, 0, 0); lit("n1_l", 6'h00); tick();
    go(0, 0, 0, 0, 0, 0); tick();

    go(0, 1, 5, 0, 0, 0); tick();
    go(0, 1, 5, 0, 0, 0); tick();
    go(1, 1, 5, 1, 0, 1); lit("fl_busy", 6'h00);
    chk("fl_bz", {7'd0, bus.ex_mc_busy}, 8'd1);
    tick();
    go(0, 0, 0, 0, 0, 0);
    chk("fl_idle", {7'd0, bus.ex_mc_busy}, 8'd0);
    tick();

    go(0, 0, 0, 1, 0, 0); tick();
    go(0, 0, 0, 1, 0, 0); tick();
    go(0, 0, 0, 1, 0, 1); lit("fl_wait", 6'h00); tick();
    for (int i = 0; i < 4; i++) begin
      go(0, 0, 0, 1, 0, 0); lit("fl_rst", 6'h1f); tick();
    end
    go(0, 0, 0, 1, 0, 0);
    chk("fl_to", {7'd0, bus.mem_timeout}, 8'd1);
    tick();
    go(0, 0, 0, 0, 0, 0); tick();

    go(0, 1, 5, 0, 0, 0); tick();
    set_in(0, 1, 5, 1, 0, 0);
    #2;
    lit("ar_pre", 6'h1f);
    rst = 1'b0;
    #1;
    lit("ar_stall", 6'h00);
    chk("ar_busy", {7'd0, bus.ex_mc_busy}, 8'd0);
    chk("ar_last", {7'd0, bus.ex_mc_last}, 8'd0);
    tick();
    set_in(0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    go(0, 0, 0, 1, 0, 0); lit("ar_after", 6'h1f); tick();
    go(0, 0, 0, 0, 0, 0); tick();
    tick();

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Pipeline stall/sequencing controller for the 6-stage core (pc, if, id, ex, mem, wb).
- Merges stall requests from ID, from EX multi-cycle ops (madd/msub/div) and from the MEM bus handshake.
- Drives the stall[5:0] vector consumed by pc_reg, if_id, id_ex, ex_mem and mem_wb.
- Owns the EX multi-cycle cycle counter and the MEM bus-wait timeout counter.

Parameters:
- CNT_W, 6, width of EX multi-cycle count input/counter.
- TIMEOUT, 255, MEM wait cycles before bus-error abort (1..2^TO_W-1).
- TO_W, 8, width of MEM timeout counter.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- flush  in  1  synchronous pipeline flush (exception/eret); aborts both FSMs
- stallreq_id  in  1  ID load-use/operand hazard stall request
- ex_mc_start  in  1  EX holds a multi-cycle op (level, held while instr sits in EX)
- ex_mc_cycles  in  CNT_W  extra EX cycles required (0 = single-cycle)
- mem_req  in  1  MEM stage issues a bus access this cycle
- mem_ack  in  1  bus acknowledges access
- stall  out  6  bit i = 1 (`Stop) freezes stage i; bit0 pc .. bit5 wb
- ex_mc_busy  out  1  EX FSM in BUSY
- ex_mc_last  out  1  final EX cycle; EX unit latches result
- mem_timeout  out  1  1-cycle pulse, bus access aborted

Behaviour:
- Reset (rst=0, async): both FSMs IDLE, counters 0; stall=0, ex_mc_busy=0, ex_mc_last=0, mem_timeout=0, regardless of inputs.
- stall is combinational from state and inputs. Priority (downstream wins):
  - mem_stall -> 6'b011111
  - ex_stall -> 6'b001111
  - stallreq_id -> 6'b000111
  - else 6'b000000
- Encodings guarantee ex_mem bubble insertion only for ex_stall (stall[3]=1, stall[4]=0).
- flush=1: stall=0 that cycle; both FSMs -> IDLE, counters cleared at the edge; mem_timeout=0.
- EX FSM states IDLE, BUSY:
  - IDLE, ex_mc_start=1, ex_mc_cycles=N>0, mem_stall=0: ex_stall=1; cnt<=N-1; -> BUSY.
  - IDLE with N=0, or while mem_stall=1: no action. The instr is frozen; start re-evaluated next cycle.
  - BUSY, cnt!=0: ex_stall=1; cnt decrements only when mem_stall=0.
  - BUSY, cnt==0: ex_mc_last=1, ex_stall=0. If mem_stall=0 -> IDLE (instr leaves EX). If mem_stall=1, hold BUSY with ex_mc_last still 1.
  - Total EX occupancy without MEM stalls = N+1 cycles; ex_stall asserted N cycles.
  - ex_mc_start dropping in BUSY (not via flush) is a protocol error; FSM still completes its count.
- MEM FSM states IDLE, WAIT:
  - IDLE, mem_req & mem_ack: no stall.
  - IDLE, mem_req & !mem_ack: mem_stall=1; tcnt<=1; -> WAIT.
  - WAIT, mem_ack=1: mem_stall=0 that cycle; -> IDLE; tcnt<=0.
  - WAIT, !mem_ack, tcnt<TIMEOUT: mem_stall=1; tcnt++.
  - WAIT, !mem_ack, tcnt==TIMEOUT: mem_stall=0, mem_timeout=1 (one cycle); -> IDLE.
  - WAIT, mem_req=0: mem_stall=0; -> IDLE.
  - Ack and timeout in the same cycle: ack wins, no mem_timeout.
- Simultaneous EX and MEM stall: stall=6'b011111; EX counter frozen.
- Reset mid-operation: immediate return to IDLE, stall=0.

Decomposition:
- Defines.v gets:
  - `StallNone 6'b000000, `StallId 6'b000111, `StallEx 6'b001111, `StallMem 6'b011111
  - EX state codes `McIdle/`McBusy
  - MEM state codes `MwIdle/`MwWait
  - Stop/NoStop already shared.
- One sub-module, mc_counter: loadable down-counter with enable and zero flag, used for the EX count. The MEM timeout counter stays inline.

Test Plan:
- ID hazard: stallreq_id=1 one cycle, no others -> stall=6'b000111 that cycle only.
- EX op N=3: ex_mc_start held -> stall=6'b001111 for 3 cycles; ex_mc_last=1 in the 4th with stall=0; busy 3 cycles.
- Overlap: EX op N=2 issued while MEM waits 2 cycles for ack -> stall=6'b011111 for 2 cycles, then EX sequence 2 stall cycles + last.
- MEM wait: mem_req=1, ack after 4 cycles -> stall=6'b011111 for 4 cycles, 0 on ack cycle.
- Timeout TIMEOUT=4: mem_req held, no ack -> 4 stall cycles, then mem_timeout=1 and stall=0; ack+timeout same cycle -> no pulse.
- flush and async reset in BUSY/WAIT -> stall=0 that cycle, FSMs IDLE; rst low mid-cycle clears outputs without a clock edge.
